// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity modes, FSM states, frame sizing.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_t;

  // Number of bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

  // Parity bit for a word zero-extended to 9 bits; zero padding does not change the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input int parity);
    return (parity == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level output, shared by the UART transmit and future receive paths.
// Latency: a pushed word is visible on o_data and counted in o_level one edge after the push.
// Backpressure: pushes are ignored while full, pops are ignored while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LVL_FULL);
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Storage: written only on an accepted push; contents are don't-care until counted.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; pointers are log2(DEPTH) wide so they wrap on their own.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words enter a FIFO over valid/ready and leave serially on o_txd.
// Latency: a word accepted into an empty FIFO while idle starts its start bit one edge later.
// Backpressure: o_ready drops while the FIFO is full; frames are sent back to back while words remain.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  input  logic [DATA_BITS-1:0]        i_data,
  output logic                        o_ready,
  output logic                        o_txd,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_level
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic            STOP_LAST = (STOP_BITS == 2);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < PARITY_NONE || PARITY > PARITY_EVEN ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_fifo: illegal parameter combination");
  end

  uart_state_t          r_state;
  uart_state_t          w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [3:0]           r_bit_idx;
  logic [3:0]           w_bit_idx_nxt;
  logic                 r_stop_idx;
  logic                 w_stop_idx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_par;
  logic                 w_par_nxt;
  logic                 r_txd;
  logic                 w_txd_nxt;
  logic                 w_tick;
  logic                 w_load;

  logic [DATA_BITS-1:0]        w_fifo_data;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_level;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_valid),
    .i_data  (i_data),
    .i_pop   (w_load),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  assign o_ready = !w_fifo_full;
  assign o_level = w_fifo_level;
  assign o_busy  = (r_state != S_IDLE);
  assign o_txd   = r_txd;
  assign w_tick  = (r_cnt == CNT_LAST);

  // Next-state logic: bit sequencing, FIFO pop, and the registered line value for the next cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_shift_nxt    = r_shift;
    w_par_nxt      = r_par;
    w_load         = 1'b0;
    w_txd_nxt      = 1'b1;

    if (r_state != S_IDLE) begin
      w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_load    = !w_fifo_empty;
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == BIT_LAST) begin
            w_state_nxt    = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
            w_stop_idx_nxt = 1'b0;
          end else begin
            w_shift_nxt   = r_shift >> 1;
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_nxt    = S_STOP;
          w_stop_idx_nxt = 1'b0;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_stop_idx == STOP_LAST) begin
            // Chain straight into the next start bit when a word is waiting.
            w_state_nxt = S_IDLE;
            w_load      = !w_fifo_empty;
          end else begin
            w_stop_idx_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_load) begin
      w_state_nxt = S_START;
      w_cnt_nxt   = '0;
      w_shift_nxt = w_fifo_data;
      w_par_nxt   = parity_bit(9'(w_fifo_data), PARITY);
    end

    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_shift_nxt[0];
      S_PARITY: w_txd_nxt = w_par_nxt;
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  // State register; reset abandons any frame and returns the line high on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_par      <= w_par_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: five parameter sets share one stimulus schedule and one frame-level model.
// Latency: model expects the start bit one edge after the accept edge into an idle, empty FIFO.
// Backpressure: model applies ready = (level != depth) and back-to-back framing.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int NI = 5;

  function automatic int cfg_cpb(input int i);
    return (i == 4) ? 2 : 4;
  endfunction
  function automatic int cfg_db(input int i);
    case (i)
      3:       return 7;
      4:       return 9;
      default: return 8;
    endcase
  endfunction
  function automatic int cfg_par(input int i);
    case (i)
      1:       return 2;
      2:       return 1;
      4:       return 2;
      default: return 0;
    endcase
  endfunction
  function automatic int cfg_stop(input int i);
    return (i == 3 || i == 4) ? 2 : 1;
  endfunction
  function automatic int cfg_dep(input int i);
    case (i)
      2:       return 2;
      3:       return 8;
      4:       return 2;
      default: return 4;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic       valid [NI];
  logic [8:0] data  [NI];
  logic       ready [NI];
  logic       txd   [NI];
  logic       busy  [NI];
  logic [3:0] level [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D  = cfg_db(g);
    localparam int DP = cfg_dep(g);
    logic [$clog2(DP):0] w_lvl;
    uart_tx_fifo #(
      .CLKS_PER_BIT (cfg_cpb(g)),
      .DATA_BITS    (D),
      .PARITY       (cfg_par(g)),
      .STOP_BITS    (cfg_stop(g)),
      .FIFO_DEPTH   (DP)
    ) u_dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (valid[g]),
      .i_data  (data[g][D-1:0]),
      .o_ready (ready[g]),
      .o_txd   (txd[g]),
      .o_busy  (busy[g]),
      .o_level (w_lvl)
    );
    assign level[g] = 4'(w_lvl);
  end

  // ---------------- frame-level reference model ----------------
  function automatic logic [12:0] mk_frame(input int i, input logic [8:0] d);
    logic [12:0] f;
    int          db;
    db   = cfg_db(i);
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < db; k++) f[1 + k] = d[k];
    if (cfg_par(i) == 2) f[1 + db] = ($countones(d) % 2 == 1);
    else if (cfg_par(i) == 1) f[1 + db] = ($countones(d) % 2 == 0);
    return f;
  endfunction

  function automatic int frame_len(input int i);
    return 1 + cfg_db(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_stop(i);
  endfunction

  logic [8:0]  mq   [NI][16];
  int          mhd  [NI];
  int          mcnt [NI];
  bit          mact [NI];
  bit          macc [NI];
  logic [12:0] mfb  [NI];
  int          mfc  [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      bit acc;
      if (rst) begin
        mcnt[i] = 0;
        mhd[i]  = 0;
        mact[i] = 0;
        mfc[i]  = 0;
        macc[i] = 0;
      end else begin
        acc = valid[i] && (mcnt[i] != cfg_dep(i));
        if (mact[i]) begin
          mfc[i]++;
          if (mfc[i] == frame_len(i) * cfg_cpb(i)) mact[i] = 0;
        end
        if (!mact[i] && mcnt[i] > 0) begin
          mfb[i]  = mk_frame(i, mq[i][mhd[i]]);
          mfc[i]  = 0;
          mact[i] = 1;
          mhd[i]  = (mhd[i] + 1) % 16;
          mcnt[i]--;
        end
        if (acc) begin
          mq[i][(mhd[i] + mcnt[i]) % 16] = data[i] & 9'((1 << cfg_db(i)) - 1);
          mcnt[i]++;
        end
        macc[i] = acc;
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check("txd",   i, int'(txd[i]),   mact[i] ? int'(mfb[i][mfc[i] / cfg_cpb(i)]) : 1);
        check("busy",  i, int'(busy[i]),  int'(mact[i]));
        check("level", i, int'(level[i]), mcnt[i]);
        check("ready", i, int'(ready[i]), (mcnt[i] != cfg_dep(i)) ? 1 : 0);
      end
    end
  end

  task automatic run_random(input int cycles, input int pct);
    repeat (cycles) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (valid[i] && macc[i]) valid[i] = 1'b0;
        if (!valid[i] && int'($urandom_range(99)) < pct) begin
          valid[i] = 1'b1;
          data[i]  = 9'($urandom);
        end
      end
    end
  endtask

  logic rec  [NI][128];
  int   bcnt [NI];
  int   sent [NI];
  int   ones;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      valid[i] = 1'b0;
      data[i]  = '0;
      bcnt[i]  = 0;
      sent[i]  = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    check("rst_txd",   0, int'(txd[0]),   1);
    check("rst_busy",  0, int'(busy[0]),  0);
    check("rst_level", 0, int'(level[0]), 0);
    check("rst_ready", 0, int'(ready[0]), 1);
    rst = 1'b0;

    // Two words per instance from idle; record the line for 120 cycles.
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      valid[i] = 1'b1;
      data[i]  = (i == 3) ? 9'h07F : 9'h041;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("acc_level", i, int'(level[i]), 1);
      check("acc_busy",  i, int'(busy[i]),  0);
      data[i] = (i == 3) ? 9'h02A : 9'h0C3;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) valid[i] = 1'b0;
    for (int s = 0; s < 120; s++) begin
      for (int i = 0; i < NI; i++) begin
        rec[i][s] = txd[i];
        bcnt[i]  += int'(busy[i]);
      end
      @(negedge clk);
    end
    for (int i = 0; i < NI; i++) check("start_bit", i, int'(rec[i][0]), 0);
    check("c0_d0",    0, int'(rec[0][4]),  1);
    check("c0_d1",    0, int'(rec[0][8]),  0);
    check("c0_d6",    0, int'(rec[0][28]), 1);
    check("c0_d7",    0, int'(rec[0][32]), 0);
    check("c0_stop",  0, int'(rec[0][39]), 1);
    check("c0_next",  0, int'(rec[0][40]), 0);
    check("c1_even",  1, int'(rec[1][36]), 0);
    check("c1_stop",  1, int'(rec[1][40]), 1);
    check("c1_next",  1, int'(rec[1][44]), 0);
    check("c1_even2", 1, int'(rec[1][80]), 0);
    check("c2_odd",   2, int'(rec[2][36]), 1);
    check("c2_odd2",  2, int'(rec[2][80]), 1);
    ones = 0;
    for (int s = 4; s < 32; s++) ones += int'(rec[3][s]);
    check("c3_ones",  3, ones, 28);
    check("c3_stop1", 3, int'(rec[3][32]), 1);
    check("c3_stop2", 3, int'(rec[3][39]), 1);
    check("c3_next",  3, int'(rec[3][40]), 0);
    check("c4_d0",    4, int'(rec[4][2]),  1);
    check("c4_d6",    4, int'(rec[4][14]), 1);
    check("c4_d8",    4, int'(rec[4][18]), 0);
    check("c4_par",   4, int'(rec[4][20]), 0);
    check("c4_stop",  4, int'(rec[4][25]), 1);
    check("c4_next",  4, int'(rec[4][26]), 0);
    check("busy_len", 0, bcnt[0], 80);
    check("busy_len", 1, bcnt[1], 88);
    check("busy_len", 2, bcnt[2], 88);
    check("busy_len", 3, bcnt[3], 80);
    check("busy_len", 4, bcnt[4], 52);

    // Reset during data bit 3 of instance 0 with words still queued.
    for (int i = 0; i < NI; i++) begin
      valid[i] = 1'b1;
      data[i]  = 9'($urandom);
    end
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) data[i] = 9'($urandom);
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) valid[i] = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("mid_rst_txd",   i, int'(txd[i]),   1);
      check("mid_rst_busy",  i, int'(busy[i]),  0);
      check("mid_rst_level", i, int'(level[i]), 0);
    end
    rst  = 1'b0;
    ones = 0;
    repeat (200) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) ones += int'(txd[i]) + int'(busy[i] == 1'b0);
    end
    check("post_rst_idle", 0, ones, 2000);

    // Hold valid for six words per instance from idle.
    for (int i = 0; i < NI; i++) begin
      valid[i] = 1'b1;
      data[i]  = 9'($urandom);
      sent[i]  = 0;
    end
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (valid[i] && macc[i]) begin
          sent[i]++;
          data[i] = 9'($urandom);
        end
        valid[i] = (sent[i] < 6);
      end
      if (k == 4)  check("fill_lvl3",  0, int'(level[0]), 3);
      if (k == 5)  check("fill_full",  0, int'(level[0]) * 2 + int'(ready[0]), 8);
      if (k == 41) check("fill_hold",  0, int'(level[0]) * 2 + int'(ready[0]), 8);
      if (k == 42) check("fill_pop",   0, int'(level[0]) * 2 + int'(ready[0]), 7);
      if (k == 43) check("fill_sixth", 0, int'(level[0]) * 10 + sent[0], 46);
    end

    // Random traffic: heavy load, then sparse load, then drain.
    run_random(1500, 40);
    run_random(1500, 3);
    for (int i = 0; i < NI; i++) valid[i] = 1'b0;
    repeat (400) @(negedge clk);
    for (int i = 0; i < NI; i++) check("drained", i, int'(busy[i]) + int'(level[i]), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
